// File: rtl/polar_pkg.sv
// Shared polar-decoder definitions: LLR width default, magnitude ceiling and PE modes.
// Latency: n/a (package). Backpressure: n/a.
// Imported by the PE and its converter.
package polar_pkg;

    localparam int LLR_W_DFLT = 9;

    function automatic int mag_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    localparam int MAG_MAX = mag_max(LLR_W_DFLT);

    typedef enum logic {
        PE_F = 1'b0,
        PE_G = 1'b1
    } pe_mode_t;

endpackage

// File: rtl/sign_to_two.sv
// Sign-magnitude to (LLR_W+1)-bit two's-complement converter; negative zero maps to 0.
// Latency: combinational. Backpressure: none.
// One instance per LLR operand in the PE's first stage.
module sign_to_two
    import polar_pkg::*;
#(
    parameter int LLR_W = LLR_W_DFLT
) (
    input  logic [LLR_W-1:0] sm,
    output logic [LLR_W:0]   tc
);

    logic [LLR_W:0] mag_ext;

    assign mag_ext = {2'b00, sm[LLR_W-2:0]};
    // Negating a zero magnitude wraps back to zero, so -0 needs no special case.
    assign tc      = sm[LLR_W-1] ? (~mag_ext + 1'b1) : mag_ext;

endmodule

// File: rtl/polar_pe_fg.sv
// Polar SC processing element: f (min-sum) or g (partial-sum add/sub) on two sign-magnitude LLRs.
// Latency: 2 cycles from acceptance to out_valid; one op per cycle sustained.
// Backpressure: valid/ready skid-free pipeline, each stage advances when the stage ahead is free.
module polar_pe_fg
    import polar_pkg::*;
#(
    parameter int LLR_W = LLR_W_DFLT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic             in_u,
    input  logic [LLR_W-1:0] in_a,
    input  logic [LLR_W-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LLR_W-1:0] out_llr,
    output logic             out_hard,
    output logic [CNT_W-1:0] sat_cnt
);

    localparam logic signed [LLR_W:0] CLIP_POS = (LLR_W+1)'(mag_max(LLR_W));
    localparam logic signed [LLR_W:0] CLIP_NEG = -CLIP_POS;
    localparam logic [CNT_W-1:0]      CNT_MAX  = '1;

    logic                    adv1;
    logic                    adv2;
    logic [LLR_W:0]          a_tc;
    logic [LLR_W:0]          b_tc;

    logic                    s1_valid;
    pe_mode_t                s1_mode;
    logic                    s1_u;
    logic signed [LLR_W:0]   s1_a;
    logic signed [LLR_W:0]   s1_b;
    logic                    s2_valid;

    logic signed [LLR_W:0]   abs_a;
    logic signed [LLR_W:0]   abs_b;
    logic signed [LLR_W:0]   g_sum;
    logic signed [LLR_W:0]   g_res;
    logic signed [LLR_W:0]   g_abs;
    logic                    g_clip;
    logic [LLR_W-2:0]        res_mag;
    logic                    res_sign;

    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    sign_to_two #(.LLR_W(LLR_W)) u_conv_a (.sm(in_a), .tc(a_tc));
    sign_to_two #(.LLR_W(LLR_W)) u_conv_b (.sm(in_b), .tc(b_tc));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= PE_F;
            s1_u     <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= pe_mode_t'(in_mode);
                s1_u    <= in_u;
                s1_a    <= $signed(a_tc);
                s1_b    <= $signed(b_tc);
            end
        end
    end

    always_comb begin
        abs_a    = s1_a[LLR_W] ? -s1_a : s1_a;
        abs_b    = s1_b[LLR_W] ? -s1_b : s1_b;
        g_sum    = s1_u ? (s1_b - s1_a) : (s1_b + s1_a);
        g_clip   = 1'b0;
        g_res    = g_sum;
        if (g_sum > CLIP_POS) begin
            g_res  = CLIP_POS;
            g_clip = 1'b1;
        end else if (g_sum < CLIP_NEG) begin
            g_res  = CLIP_NEG;
            g_clip = 1'b1;
        end
        g_abs    = g_res[LLR_W] ? -g_res : g_res;
        res_mag  = '0;
        res_sign = 1'b0;
        if (s1_mode == PE_F) begin
            res_mag  = (abs_a < abs_b) ? abs_a[LLR_W-2:0] : abs_b[LLR_W-2:0];
            // A zero minimum must not carry a sign.
            res_sign = (s1_a[LLR_W] ^ s1_b[LLR_W]) && (res_mag != '0);
        end else begin
            res_mag  = g_abs[LLR_W-2:0];
            res_sign = g_res[LLR_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_llr  <= '0;
            out_hard <= 1'b0;
            sat_cnt  <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_llr  <= {res_sign, res_mag};
                out_hard <= res_sign;
                if ((s1_mode == PE_G) && g_clip && (sat_cnt != CNT_MAX))
                    sat_cnt <= sat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_polar_pe_fg.sv
// Scoreboard bench for polar_pe_fg: directed f/g cases, latency, backpressure, reset, random traffic.
module tb_polar_pe_fg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic        in_u;
    logic [8:0]  in_a;
    logic [8:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_llr;
    logic        out_hard;
    logic [15:0] sat_cnt;

    int          vec = 0;
    int          errs = 0;
    int          exp_sat = 0;
    logic [8:0]  exp_q[$];
    bit          rnd_done;

    always #5 clk = ~clk;

    polar_pe_fg #(.LLR_W(9), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_u(in_u),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_llr(out_llr), .out_hard(out_hard), .sat_cnt(sat_cnt)
    );

    // Reference: bit 9 = clipped flag, bits 8:0 = sign-magnitude result.
    function automatic logic [9:0] model(bit m, bit u, logic [8:0] a, logic [8:0] b);
        int ma, mb, va, vb, r;
        bit sa, sb, clip;
        ma = int'(a[7:0]);
        mb = int'(b[7:0]);
        sa = a[8] && (ma != 0);
        sb = b[8] && (mb != 0);
        va = sa ? -ma : ma;
        vb = sb ? -mb : mb;
        if (!m) begin
            r = (ma < mb) ? ma : mb;
            if (r == 0) return 10'h000;
            return {1'b0, sa ^ sb, 8'(r)};
        end
        r = u ? (vb - va) : (vb + va);
        clip = (r > 255) || (r < -255);
        if (r > 255) r = 255;
        if (r < -255) r = -255;
        return {clip, (r < 0), 8'((r < 0) ? -r : r)};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            vec++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_output: got llr=%h, none expected", out_llr);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if (out_llr !== e || out_hard !== e[8]) begin
                    errs++;
                    $display("FAIL result: got llr=%h hard=%b, expected llr=%h hard=%b",
                             out_llr, out_hard, e, e[8]);
                end
            end
        end
    end

    task automatic send(input bit m, input bit u, input logic [8:0] a, input logic [8:0] b,
                        input logic [8:0] e, input bit c);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; in_mode = m; in_u = u; in_a = a; in_b = b;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                if (c) exp_sat++;
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            vec++; errs++;
            $display("FAIL accept_timeout: in_ready stayed low, expected acceptance");
        end
    endtask

    task automatic send_model(input bit m, input bit u, input logic [8:0] a, input logic [8:0] b);
        logic [9:0] x;
        x = model(m, u, a, b);
        send(m, u, a, b, x[8:0], x[9]);
    endtask

    task automatic drain_and_check_sat(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(posedge clk); #2;
            if (exp_q.size() == 0) done = 1'b1;
        end
        vec++;
        if (!done) begin
            errs++;
            $display("FAIL %s_drain: %0d results outstanding, expected 0", name, exp_q.size());
        end
        vec++;
        if (sat_cnt !== 16'(exp_sat)) begin
            errs++;
            $display("FAIL %s_sat_cnt: got %0d, expected %0d", name, sat_cnt, exp_sat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vec++;
        if (out_valid !== 1'b0 || out_llr !== 9'h000 || out_hard !== 1'b0 || sat_cnt !== 16'h0) begin
            errs++;
            $display("FAIL reset_state: got valid=%b llr=%h hard=%b sat=%0d, expected all 0",
                     out_valid, out_llr, out_hard, sat_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_f_latency();
        out_ready = 1'b1;
        send(1'b0, 1'b0, 9'h105, 9'h003, 9'h103, 1'b0);
        @(negedge clk);
        vec++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL f_latency_early: out_valid=%b one cycle after accept, expected 0", out_valid);
        end
        @(negedge clk);
        vec++;
        if (out_valid !== 1'b1 || out_llr !== 9'h103 || out_hard !== 1'b1) begin
            errs++;
            $display("FAIL f_latency: got valid=%b llr=%h hard=%b, expected 1 103 1",
                     out_valid, out_llr, out_hard);
        end
        drain_and_check_sat("f");
    endtask

    task automatic test_g();
        out_ready = 1'b1;
        send(1'b1, 1'b0, 9'h0C8, 9'h064, 9'h0FF, 1'b1);
        drain_and_check_sat("g_clip");
        send(1'b1, 1'b0, 9'h1C8, 9'h164, 9'h1FF, 1'b1);
        send(1'b1, 1'b1, 9'h005, 9'h003, 9'h102, 1'b0);
        send(1'b1, 1'b1, 9'h003, 9'h003, 9'h000, 1'b0);
        send(1'b0, 1'b0, 9'h100, 9'h107, 9'h000, 1'b0);
        send(1'b0, 1'b1, 9'h005, 9'h103, 9'h103, 1'b0);
        send(1'b1, 1'b1, 9'h100, 9'h005, 9'h005, 1'b0);
        send(1'b1, 1'b1, 9'h1FF, 9'h0FF, 9'h0FF, 1'b1);
        drain_and_check_sat("g_mix");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(1'b0, 1'b0, 9'h105, 9'h003, 9'h103, 1'b0);
        send(1'b1, 1'b0, 9'h0C8, 9'h064, 9'h0FF, 1'b1);
        fork
            begin
                send(1'b1, 1'b1, 9'h005, 9'h003, 9'h102, 1'b0);
                send(1'b0, 1'b0, 9'h100, 9'h107, 9'h000, 1'b0);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    vec++;
                    if (in_ready !== 1'b0) begin
                        errs++;
                        $display("FAIL bp_in_ready: got %b in stall cycle %0d, expected 0", in_ready, k);
                    end
                    vec++;
                    if (out_valid !== 1'b1 || out_llr !== 9'h103 || out_hard !== 1'b1) begin
                        errs++;
                        $display("FAIL bp_hold: got valid=%b llr=%h hard=%b, expected 1 103 1",
                                 out_valid, out_llr, out_hard);
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain_and_check_sat("bp");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(1'b1, 1'b0, 9'h0C8, 9'h064, 9'h0FF, 1'b1);
        send(1'b0, 1'b0, 9'h105, 9'h003, 9'h103, 1'b0);
        vec++;
        if (out_valid !== 1'b1 || sat_cnt !== 16'(exp_sat)) begin
            errs++;
            $display("FAIL rst_mid_prefill: got valid=%b sat=%0d, expected 1 %0d",
                     out_valid, sat_cnt, exp_sat);
        end
        #2 rst = 1'b1;
        #1;
        vec++;
        if (out_valid !== 1'b0 || sat_cnt !== 16'h0 || out_llr !== 9'h000 || out_hard !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid_clear: got valid=%b sat=%0d llr=%h hard=%b, expected 0 0 000 0",
                     out_valid, sat_cnt, out_llr, out_hard);
        end
        exp_q.delete();
        exp_sat = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        vec++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL rst_mid_in_ready: got %b, expected 1", in_ready);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vec++;
            if (out_valid !== 1'b0) begin
                errs++;
                $display("FAIL rst_mid_stale: out_valid=%b llr=%h after reset, expected 0", out_valid, out_llr);
            end
        end
        @(posedge clk); #1;
        send(1'b1, 1'b1, 9'h005, 9'h003, 9'h102, 1'b0);
        drain_and_check_sat("rst_mid_post");
    endtask

    task automatic test_random();
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 60; k++)
                    send_model(1'($urandom), 1'($urandom), 9'($urandom), 9'($urandom));
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain_and_check_sat("random");
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_u = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b1;
        test_reset();
        test_f_latency();
        test_g();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/polar_pe_fg.md
POLAR_PE_FG -- requirements
Module: polar_pe_fg

Interface
REQ-001 SHALL have parameter LLR_W, default 9: LLR width in sign-magnitude; bit LLR_W-1 is the sign and the lower bits are the magnitude.
REQ-002 SHALL have parameter CNT_W, default 16: width of the saturation counter.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: an operation is presented.
REQ-006 SHALL have port in_ready, output, 1: the block accepts the operation this cycle.
REQ-007 SHALL have port in_mode, input, 1: 0 selects the f function, 1 selects the g function.
REQ-008 SHALL have port in_u, input, 1: partial-sum bit, used in g mode only.
REQ-009 SHALL have port in_a, input, LLR_W: LLR alpha_a, sign-magnitude.
REQ-010 SHALL have port in_b, input, LLR_W: LLR alpha_b, sign-magnitude.
REQ-011 SHALL have port out_valid, output, 1: a result is presented.
REQ-012 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-013 SHALL have port out_llr, output, LLR_W: the result, sign-magnitude.
REQ-014 SHALL have port out_hard, output, 1: hard decision, equal to the sign bit of out_llr.
REQ-015 SHALL have port sat_cnt, output, CNT_W: count of g results that were clipped.

Function
REQ-016 SHALL accept an operation when in_valid && in_ready, and deliver the result when out_valid && out_ready.
REQ-017 SHALL be a 2-stage pipeline (s1: decode/convert, s2: compute/format); with no backpressure, a result SHALL appear 2 cycles after acceptance.
REQ-018 SHALL advance s2 when adv2 = !s2_valid || out_ready, and s1 when adv1 = !s1_valid || adv2.
REQ-019 SHALL drive in_ready = adv1 combinationally, with no dependency on in_valid.
REQ-020 SHALL hold out_llr and out_hard stable while out_valid && !out_ready.
REQ-021 SHALL sustain one operation per cycle when out_ready stays high.
REQ-022 SHALL deliver results in acceptance order and never drop or duplicate one.
REQ-023 SHALL treat negative zero (sign=1, mag=0) on in_a or in_b as +0.
REQ-024 SHALL compute f as: sign = sign_a XOR sign_b; mag = min(mag_a, mag_b).
REQ-025 SHALL compute g as: convert both inputs to (LLR_W+1)-bit two's complement, then result = b + a when u=0, or b - a when u=1.
REQ-026 SHALL clip the g result to ±(2^(LLR_W-1)-1) and then convert it back to sign-magnitude.
REQ-027 SHALL never output negative zero; any zero-magnitude result SHALL be driven as all-zeros with out_hard = 0.
REQ-028 SHALL increment sat_cnt once for each clipped g result, at the moment that result enters s2.
REQ-029 SHALL hold sat_cnt at all-ones once it reaches all-ones (no wrap).
REQ-030 SHALL ignore in_u in f mode.

Reset
REQ-031 SHALL, when rst is asserted, immediately clear s1_valid, s2_valid, out_valid, out_llr, out_hard and sat_cnt to 0.
REQ-032 SHALL discard any operations in flight when reset is asserted mid-operation.
REQ-033 SHALL deliver no result derived from pre-reset inputs after rst deasserts.
REQ-034 SHALL assert in_ready in the first cycle after rst deasserts.

Structure
REQ-035 SHALL take from shared package polar_pkg: LLR_W default, MAG_MAX, and the pe_mode_t enum {PE_F, PE_G}.
REQ-036 SHALL instantiate sub-module sign_to_two (sign-magnitude to two's-complement, LLR_W in, LLR_W+1 out) twice in s1.
REQ-037 SHALL perform the reverse conversion inline in s2.

Verification
REQ-038 SHALL cover f: a=9'h105, b=9'h003 -> out_llr=9'h103, out_hard=1, out_valid exactly 2 cycles after acceptance.
REQ-039 SHALL cover g clip: u=0, a=9'h0C8, b=9'h064 -> out_llr=9'h0FF, sat_cnt=1.
REQ-040 SHALL cover g subtract: u=1, a=9'h005, b=9'h003 -> out_llr=9'h102, out_hard=1; and u=1, a=9'h003, b=9'h003 -> 9'h000, out_hard=0.
REQ-041 SHALL cover negative zero: f with a=9'h100, b=9'h107 -> out_llr=9'h000, out_hard=0.
REQ-042 SHALL cover backpressure: 4 back-to-back ops with out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, all 4 results in order, output stable while stalled.
REQ-043 SHALL cover reset mid-operation: rst pulsed with s1 and s2 full -> out_valid=0 and sat_cnt=0 immediately, no stale result afterwards, in_ready=1 the next cycle.
